// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: credit-based fetch requests to instruction memory,
// an in-order tag FIFO for in-flight addresses, and a DEPTH-entry instruction
// queue toward decode. Redirects (flush) empty the queue and drain stale
// responses before fetching resumes.
// Optional feature: define IFQ_PERF_COUNT_EN to enable the fetchCount counter.
`timescale 1ns/1ps

module inst_fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] curPC,
    output logic        PCWre,
    input  logic        flush,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic        imemRvalid,
    input  logic [31:0] imemRdata,
    output logic        instValid,
    input  logic        instReady,
    output logic [31:0] instOut,
    output logic [31:0] instPC,
    output logic [31:0] fetchCount
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] discard;
    logic [CW-1:0] discard_nxt;

    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW:0]   credit_sum;
    logic [PW-1:0] q_wr;
    logic [PW-1:0] q_rd;
    logic [PW-1:0] t_wr;
    logic [PW-1:0] t_rd;

    logic [31:0]   q_inst [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   t_addr [DEPTH];

    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;

    // Handshake qualifiers; a response with nothing in flight is ignored
    assign credit_sum = {1'b0, count} + {1'b0, outstanding};
    assign req_fire   = imemReq & imemReady;
    assign rsp_fire   = imemRvalid & (outstanding != '0);
    assign push       = rsp_fire & (state == RUN) & ~flush;
    assign pop        = instValid & instReady & ~flush;

    // Word-aligned request address, held at zero while in reset
    assign imemAddr   = RST ? 32'h0 : (curPC & 32'hFFFF_FFFC);
    assign PCWre      = req_fire | flush;

    // Head of the instruction queue presented to decode
    assign instValid  = (count != '0);
    assign instOut    = instValid ? q_inst[q_rd] : 32'h0;
    assign instPC     = instValid ? q_pc[q_rd]   : 32'h0;

    // FSM state and discard counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= RUN;
            discard <= '0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
        end
    end

    // Next-state, discard bookkeeping and request enable
    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        imemReq     = 1'b0;
        case (state)
            RUN: begin
                imemReq = ~flush & (credit_sum < (CW+1)'(DEPTH));
                if (flush) begin
                    discard_nxt = outstanding - CW'(rsp_fire);
                    state_nxt   = (discard_nxt != '0) ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (rsp_fire && (discard != '0)) begin
                    discard_nxt = discard - CW'(1);
                end
                if (discard_nxt == '0) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // Occupancy counters and FIFO pointers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count       <= '0;
            outstanding <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            t_wr        <= '0;
            t_rd        <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            if (req_fire) begin
                t_wr <= t_wr + PW'(1);
            end
            if (rsp_fire) begin
                t_rd <= t_rd + PW'(1);
            end
            if (flush) begin
                count <= '0;
                q_rd  <= q_wr;
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (push) begin
                    q_wr <= q_wr + PW'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + PW'(1);
                end
            end
        end
    end

    // Storage for in-flight tags and queued instructions
    always_ff @(posedge CLK) begin
        if (req_fire) begin
            t_addr[t_wr] <= imemAddr;
        end
        if (push) begin
            q_inst[q_wr] <= imemRdata;
            q_pc[q_wr]   <= t_addr[t_rd];
        end
    end

`ifdef IFQ_PERF_COUNT_EN
    logic [31:0] fetch_cnt;

    // Delivered-instruction counter, wraps naturally at 2^32
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_cnt <= 32'h0;
        end else if (pop) begin
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign fetchCount = fetch_cnt;
`else
    assign fetchCount = 32'h0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: PC register and in-order memory model,
// hand-sequenced steps with immediate-assertion checks.
`timescale 1ns/1ps

module tb_inst_fetch_queue;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] curPC;
    logic        PCWre;
    logic        flush;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady;
    logic        imemRvalid;
    logic [31:0] imemRdata;
    logic        instValid;
    logic        instReady;
    logic [31:0] instOut;
    logic [31:0] instPC;
    logic [31:0] fetchCount;

    int          checks = 0;
    int          errors = 0;
    int          hs;
    int          hs0;
    int          acc;
    logic [31:0] exp_pc;
    logic [31:0] flush_target;
    logic        mem_hold;
    logic        spur;
    logic [31:0] pend_mem [64];
    logic [5:0]  ph;
    logic [5:0]  pt;

    inst_fetch_queue #(.DEPTH(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .curPC      (curPC),
        .PCWre      (PCWre),
        .flush      (flush),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemReady  (imemReady),
        .imemRvalid (imemRvalid),
        .imemRdata  (imemRdata),
        .instValid  (instValid),
        .instReady  (instReady),
        .instOut    (instOut),
        .instPC     (instPC),
        .fetchCount (fetchCount)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory returns one response per cycle in request order unless held
    assign imemRvalid = ((pt != ph) && !mem_hold) || spur;
    assign imemRdata  = word_of(pend_mem[ph]);

    // PC register and memory request tracking
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ph    <= 6'd0;
            pt    <= 6'd0;
            curPC <= 32'h0040_0000;
        end else begin
            if ((pt != ph) && !mem_hold) ph <= ph + 6'd1;
            if (imemReq && imemReady) begin
                pend_mem[pt] <= imemAddr;
                pt <= pt + 6'd1;
            end
            if (PCWre) curPC <= flush ? flush_target : curPC + 32'd4;
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check and account for the head if decode takes it this cycle
    task automatic consume();
        if (instValid && instReady) begin
            chk("inst_pc", instPC, exp_pc);
            chk("inst_word", instOut, word_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            hs++;
        end
    endtask

    initial begin
        flush = 1'b0; imemReady = 1'b0; instReady = 1'b0;
        mem_hold = 1'b0; spur = 1'b0; flush_target = 32'h0;
        hs = 0; hs0 = 0; acc = 0; exp_pc = 32'h0040_0000;
        step(); step();

        // Reset state
        chk("rst_inst_valid", 32'(instValid), 32'd0);
        chk("rst_inst_out", instOut, 32'h0);
        chk("rst_inst_pc", instPC, 32'h0);
        chk("rst_fetch_count", fetchCount, 32'h0);
        chk("rst_imem_addr", imemAddr, 32'h0);
        chk("rst_imem_req", 32'(imemReq), 32'd1);
        chk("rst_pcwre", 32'(PCWre), 32'd0);

        // First fetch, minimum latency
        RST = 1'b0; imemReady = 1'b1; instReady = 1'b1;
        #1;
        chk("first_addr", imemAddr, 32'h0040_0000);
        chk("first_req", 32'(imemReq), 32'd1);
        chk("first_pcwre", 32'(PCWre), 32'd1);
        step();
        chk("lat_not_yet", 32'(instValid), 32'd0);
        step();
        chk("lat_valid", 32'(instValid), 32'd1);
        chk("lat_pc", instPC, 32'h0040_0000);
        for (int i = 0; i < 6; i++) begin consume(); step(); end

        // Drain to idle
        imemReady = 1'b0;
        for (int i = 0; i < 4; i++) begin consume(); step(); end
        chk("drained", 32'(instValid), 32'd0);
        chk("drained_addr", imemAddr, exp_pc);

        // Decode stalled: credits cap requests at queue depth
        instReady = 1'b0; imemReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (imemReq && imemReady) acc++;
            step();
        end
        chk("stall_accepts", 32'(acc), 32'd4);
        chk("stall_req", 32'(imemReq), 32'd0);
        chk("stall_pcwre", 32'(PCWre), 32'd0);
        chk("stall_head_pc", instPC, exp_pc);

        // Resume: steady push+pop at count 2 across pointer wrap
        hs0 = hs; instReady = 1'b1;
        consume(); step();
        chk("resume_req", 32'(imemReq), 32'd1);
        for (int i = 0; i < 13; i++) begin consume(); step(); end
        chk("steady_consumed", 32'(hs - hs0), 32'd14);

        // Redirect with two responses in flight
        imemReady = 1'b0;
        for (int i = 0; i < 5; i++) begin consume(); step(); end
        chk("drained2", 32'(instValid), 32'd0);
        instReady = 1'b0; mem_hold = 1'b1; imemReady = 1'b1;
        step(); step();
        flush = 1'b1; flush_target = 32'h0080_0000;
        #1;
        chk("flush_req", 32'(imemReq), 32'd0);
        chk("flush_pcwre", 32'(PCWre), 32'd1);
        step();
        flush = 1'b0; mem_hold = 1'b0; instReady = 1'b1;
        #1;
        chk("drain_req0", 32'(imemReq), 32'd0);
        chk("drain_valid0", 32'(instValid), 32'd0);
        chk("drain_addr", imemAddr, 32'h0080_0000);
        step();
        chk("drain_req1", 32'(imemReq), 32'd0);
        chk("drain_valid1", 32'(instValid), 32'd0);
        step();
        chk("run_req", 32'(imemReq), 32'd1);
        exp_pc = 32'h0080_0000;
        step();
        chk("redirect_not_yet", 32'(instValid), 32'd0);
        step();
        chk("redirect_valid", 32'(instValid), 32'd1);
        for (int i = 0; i < 4; i++) begin consume(); step(); end
        imemReady = 1'b0;
        for (int i = 0; i < 5; i++) begin consume(); step(); end
        chk("drained3", 32'(instValid), 32'd0);

        // Spurious response with nothing in flight is ignored
        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("spur_valid", 32'(instValid), 32'd0);
        step();
        chk("spur_req", 32'(imemReq), 32'd1);

        // Reset with three queued and one outstanding
        instReady = 1'b0; imemReady = 1'b1;
        for (int i = 0; i < 4; i++) step();
        imemReady = 1'b0;
        chk("pre_rst_valid", 32'(instValid), 32'd1);
        chk("pre_rst_head", instPC, exp_pc);
        chk("pre_rst_req", 32'(imemReq), 32'd0);
`ifdef IFQ_PERF_COUNT_EN
        chk("perf_count", fetchCount, 32'(hs));
`else
        chk("tied_count", fetchCount, 32'h0);
`endif
        #1;
        RST = 1'b1;
        #1;
        chk("rst2_valid", 32'(instValid), 32'd0);
        chk("rst2_out", instOut, 32'h0);
        chk("rst2_pc", instPC, 32'h0);
        chk("rst2_count", fetchCount, 32'h0);
        chk("rst2_req", 32'(imemReq), 32'd1);
        step();
        RST = 1'b0; instReady = 1'b1; imemReady = 1'b1;
        exp_pc = 32'h0040_0000;
        #1;
        chk("post_rst_addr", imemAddr, 32'h0040_0000);
        step();
        chk("post_rst_nodata", 32'(instValid), 32'd0);
        step();
        chk("post_rst_valid", 32'(instValid), 32'd1);
        for (int i = 0; i < 4; i++) begin consume(); step(); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
